// File: rtl/modport_fifo_pkg.sv
// Shared defaults for the modport_fifo slice.
// Default geometry, flag thresholds and the data word type.
package modport_fifo_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_AF_LEVEL = 28;
    localparam int DEF_AE_LEVEL = 4;

    typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/modport_fifo_mem.sv
// Dual-port storage for modport_fifo.
// Synchronous write, registered read port that holds when idle.
module modport_fifo_mem
    import modport_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Array write; contents are not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register: loads the popped word, otherwise holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/modport_fifo.sv
// Synchronous FIFO control: pointers, occupancy and status flags.
// Storage lives in modport_fifo_mem; flags decode the registered count.
module modport_fifo
    import modport_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEF_AF_LEVEL,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             lleno,
    output logic             vacio,
    output logic             casi_lleno,
    output logic             casi_vacio
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_full;
    logic w_empty;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees a slot.
    assign w_rd_acc = rd_en & ~w_empty;
    assign w_wr_acc = wr_en & (~w_full | w_rd_acc);

    // Pointer advance on accepted transfers; wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: net change of accepted write and read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign lleno      = w_full;
    assign vacio      = w_empty;
    assign casi_lleno = (r_count >= CW'(AF_LEVEL));
    assign casi_vacio = (r_count <= CW'(AE_LEVEL));

    modport_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (data_out)
    );

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo (default parameters).
// Queue scoreboard plus a small vector table and corner sequences.
module tb_modport_fifo;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       lleno;
    logic       vacio;
    logic       casi_lleno;
    logic       casi_vacio;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] sb_q[$];
    logic [7:0] exp_dout;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    modport_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .lleno      (lleno),
        .vacio      (vacio),
        .casi_lleno (casi_lleno),
        .casi_vacio (casi_vacio)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input int cnt);
        chk({name, " vacio"}, 32'(vacio), 32'(cnt == 0));
        chk({name, " lleno"}, 32'(lleno), 32'(cnt == DEPTH));
        chk({name, " casi_vacio"}, 32'(casi_vacio), 32'(cnt <= 4));
        chk({name, " casi_lleno"}, 32'(casi_lleno), 32'(cnt >= 28));
    endtask

    // One clock of stimulus; the scoreboard applies the acceptance rules.
    task automatic step(input logic wr, input logic rd,
                        input logic [7:0] din, input string name);
        logic rd_ok;
        logic wr_ok;
        wr_en   = wr;
        rd_en   = rd;
        data_in = din;
        rd_ok = rd && (sb_q.size() != 0);
        wr_ok = wr && ((sb_q.size() != DEPTH) || rd_ok);
        @(posedge clk);
        #1;
        if (rd_ok) exp_dout = sb_q.pop_front();
        if (wr_ok) sb_q.push_back(din);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk({name, " data_out"}, 32'(data_out), 32'(exp_dout));
        chk_flags(name, sb_q.size());
    endtask

    initial begin
        rst      = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        data_in  = 8'h00;
        exp_dout = 8'h00;

        tbl[0] = '{1'b1, 1'b1, 8'h5A, 1, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 8'h00, 0, 8'h5A};
        tbl[2] = '{1'b0, 1'b1, 8'h00, 0, 8'h5A};
        tbl[3] = '{1'b1, 1'b0, 8'h11, 1, 8'h5A};
        tbl[4] = '{1'b1, 1'b0, 8'h22, 2, 8'h5A};
        tbl[5] = '{1'b1, 1'b1, 8'h33, 2, 8'h11};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 1, 8'h22};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 0, 8'h33};

        #3;
        chk("reset data_out", 32'(data_out), 32'h0);
        chk_flags("reset", 0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].din, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d dout", i), 32'(data_out), 32'(tbl[i].dout));
            chk_flags($sformatf("vec%0d tbl", i), tbl[i].cnt);
        end

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        end
        chk("fill casi_lleno", 32'(casi_lleno), 32'h1);
        step(1'b1, 1'b0, 8'hAA, "write when full");
        chk("full lleno", 32'(lleno), 32'h1);

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));
            chk($sformatf("drain%0d order", i), 32'(data_out), 32'(i));
        end
        chk("drain vacio", 32'(vacio), 32'h1);
        step(1'b0, 1'b1, 8'h00, "read when empty");
        chk("empty read hold", 32'(data_out), 32'h1F);

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, 8'(8'h80 + i), $sformatf("refill%0d", i));
        end
        step(1'b1, 1'b1, 8'hC3, "full simul");
        chk("full simul lleno", 32'(lleno), 32'h1);
        chk("full simul oldest", 32'(data_out), 32'h80);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 8'h00, $sformatf("redrain%0d", i));
        end
        chk("full simul last", 32'(data_out), 32'hC3);

        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(8'h40 + i), $sformatf("pre%0d", i));
        end
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'(8'h60 + k), $sformatf("simul%0d", k));
            chk($sformatf("simul%0d order", k), 32'(data_out),
                (k < 10) ? 32'(8'h40 + k) : 32'(8'h60 + k - 10));
            chk_flags($sformatf("simul%0d occ10", k), 10);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'h00, $sformatf("post%0d", i));
            chk($sformatf("post%0d order", i), 32'(data_out),
                32'(8'h6A + i));
        end

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'(8'hE0 + i), $sformatf("pre_rst%0d", i));
        end
        #2;
        rst = 1'b0;
        #1;
        chk("async rst data_out", 32'(data_out), 32'h0);
        chk_flags("async rst", 0);
        sb_q.delete();
        exp_dout = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h77, "post rst write");
        step(1'b0, 1'b1, 8'h00, "post rst read");
        chk("post rst value", 32'(data_out), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 32, number of storage entries (power of two, >= 8).
REQ-003 Parameter AF_LEVEL, default 28, occupancy at or above which casi_lleno asserts.
REQ-004 Parameter AE_LEVEL, default 4, occupancy at or below which casi_vacio asserts.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  write request; data_in stored on the clock edge when accepted.
REQ-008 rd_en  input  1  read request; oldest word popped on the clock edge when accepted.
REQ-009 data_in  input  WIDTH  write data.
REQ-010 data_out  output  WIDTH  registered read data.
REQ-011 lleno  output  1  full: occupancy == DEPTH.
REQ-012 vacio  output  1  empty: occupancy == 0.
REQ-013 casi_lleno  output  1  almost full: occupancy >= AF_LEVEL.
REQ-014 casi_vacio  output  1  almost empty: occupancy <= AE_LEVEL.

Function
REQ-015 Storage SHALL be first-in first-out; words read out in write order, no loss, no duplication.
REQ-016 Write accepted when wr_en=1 and (lleno=0 or read accepted same edge); otherwise ignored, memory and pointers unchanged.
REQ-017 Read accepted when rd_en=1 and vacio=0; otherwise ignored and data_out holds its previous value.
REQ-018 On an accepted read, data_out SHALL present the popped word after that same rising edge (one-cycle read latency, registered output).
REQ-019 Simultaneous wr_en and rd_en when empty: write accepted, read ignored, occupancy becomes 1.
REQ-020 Simultaneous wr_en and rd_en when not empty (including full): both accepted, occupancy unchanged.
REQ-021 Occupancy counter width SHALL be clog2(DEPTH)+1 bits; range 0..DEPTH; never wraps.
REQ-022 Read and write pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
REQ-023 All four flags SHALL be decoded from the registered occupancy, updating after the edge that changes occupancy (no combinational path from wr_en/rd_en).
REQ-024 Flags may be simultaneously true (e.g. vacio and casi_vacio at occupancy 0; lleno and casi_lleno at DEPTH).

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, clear pointers and occupancy, drive data_out=0, vacio=1, casi_vacio=1, lleno=0, casi_lleno=0.
REQ-026 Reset asserted mid-operation SHALL discard all stored contents; memory array itself need not be cleared.
REQ-027 After rst deasserts, first accepted write SHALL occur no earlier than the next rising edge.

Structure
REQ-028 Package modport_fifo_pkg SHALL hold default WIDTH, DEPTH, AF_LEVEL, AE_LEVEL constants and the data word typedef.
REQ-029 Storage SHALL be a sub-module modport_fifo_mem (dual-port, synchronous write, registered read); control, pointers, counter and flags in modport_fifo.

Verification
REQ-030 Reset: rst=0 mid-stream with 5 words stored -> vacio=1, casi_vacio=1, lleno=0, casi_lleno=0, data_out=0 without waiting for clk.
REQ-031 Fill: 32 writes of 0x00..0x1F from empty -> casi_vacio drops after 5th write, casi_lleno rises after 28th, lleno after 32nd; 33rd write 0xAA ignored.
REQ-032 Drain: 32 reads after fill -> data_out 0x00..0x1F in order, each one cycle after read edge; vacio after 32nd read; 33rd read leaves data_out=0x1F.
REQ-033 Simultaneous: at occupancy 10, wr_en=rd_en=1 for 20 cycles -> occupancy stays 10, order preserved across pointer wrap.
REQ-034 Empty simultaneous: empty, wr_en=rd_en=1 with data_in=0x5A -> vacio=0, data_out unchanged; next read returns 0x5A.
REQ-035 Full simultaneous: full, wr_en=rd_en=1 with data_in=0xC3 -> lleno stays 1, oldest word output, 0xC3 later read last.
